// File: rtl/ex_writeback_rf.sv
// EX/WB pipeline register, architectural carry/zero flags and 8-entry register file with
// conditional commit and write-through bypass. Optional macro R0_ZERO_EN hardwires register 0.
module ex_writeback_rf #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned NREGS  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [15:0]       ex_ir,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic              ex_carryout,
  input  logic              ex_zeroout,
  input  logic              stall,
  input  logic              flush,
  input  logic [2:0]        rs1_addr,
  input  logic [2:0]        rs2_addr,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic              carry_flag,
  output logic              zero_flag,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [2:0]        wb_dest,
  output logic [DATA_W-1:0] wb_data
);

  localparam logic [3:0] OpAddi = 4'b0000;
  localparam logic [3:0] OpAdd  = 4'b0001;
  localparam logic [3:0] OpNand = 4'b0010;

  logic              wb_valid_q;
  logic [15:0]       wb_ir_q;
  logic [DATA_W-1:0] wb_data_q;
  logic              wb_c_q, wb_z_q;
  logic              c_q, c_d, z_q, z_d;
  logic [DATA_W-1:0] rf_q [NREGS];

  logic       capture;
  logic [3:0] op;
  logic [1:0] cc;
  logic       is_addi, is_add, is_nand, write_op;
  logic       cond_met, commit_ok, upd_c, upd_z;
  logic [2:0] dest;
  logic       unused_ir;

  assign capture   = ex_valid & ~stall & ~flush;
  assign unused_ir = ^{wb_ir_q[11:9], wb_ir_q[2]};

  always_comb begin
    op       = wb_ir_q[15:12];
    cc       = wb_ir_q[1:0];
    is_addi  = (op == OpAddi);
    is_add   = (op == OpAdd);
    is_nand  = (op == OpNand);
    write_op = is_addi | is_add | is_nand;
    dest     = is_addi ? wb_ir_q[8:6] : wb_ir_q[5:3];
    // Conditions are judged against architectural flags, never the pending ones.
    cond_met = 1'b1;
    if (is_add || is_nand) begin
      unique case (cc)
        2'b10:   cond_met = c_q;
        2'b01:   cond_met = z_q;
        default: cond_met = 1'b1;
      endcase
    end
    commit_ok = wb_valid_q & write_op & cond_met;
    upd_c     = commit_ok & (is_add | is_addi);
    upd_z     = commit_ok;
  end

  always_comb begin
    wb_we = commit_ok;
`ifdef R0_ZERO_EN
    if (dest == 3'd0) wb_we = 1'b0;
`endif
    c_d = upd_c ? wb_c_q : c_q;
    z_d = upd_z ? wb_z_q : z_q;
  end

  always_comb begin
    rd_data1 = (wb_we && rs1_addr == dest) ? wb_data_q : rf_q[rs1_addr];
    rd_data2 = (wb_we && rs2_addr == dest) ? wb_data_q : rf_q[rs2_addr];
`ifdef R0_ZERO_EN
    if (rs1_addr == 3'd0) rd_data1 = '0;
    if (rs2_addr == 3'd0) rd_data2 = '0;
`endif
    carry_flag = c_d;
    zero_flag  = z_d;
    wb_valid   = wb_valid_q;
    wb_dest    = dest;
    wb_data    = wb_data_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid_q <= 1'b0;
      wb_ir_q    <= '0;
      wb_data_q  <= '0;
      wb_c_q     <= 1'b0;
      wb_z_q     <= 1'b0;
      c_q        <= 1'b0;
      z_q        <= 1'b0;
      for (int i = 0; i < int'(NREGS); i++) rf_q[i] <= '0;
    end else begin
      wb_valid_q <= capture;
      if (capture) begin
        wb_ir_q   <= ex_ir;
        wb_data_q <= ex_alu_out;
        wb_c_q    <= ex_carryout;
        wb_z_q    <= ex_zeroout;
      end
      c_q <= c_d;
      z_q <= z_d;
      if (wb_we) rf_q[dest] <= wb_data_q;
    end
  end

endmodule

// File: tb/tb_ex_writeback_rf.sv
// Directed, table-driven bench for ex_writeback_rf; honours R0_ZERO_EN when defined.
module tb_ex_writeback_rf;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [15:0] ex_ir;
  logic [15:0] ex_alu_out;
  logic        ex_carryout, ex_zeroout, stall, flush;
  logic [2:0]  rs1_addr, rs2_addr;
  logic [15:0] rd_data1, rd_data2;
  logic        carry_flag, zero_flag, wb_valid, wb_we;
  logic [2:0]  wb_dest;
  logic [15:0] wb_data;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  ex_writeback_rf #(.DATA_W(16), .NREGS(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .ex_ir      (ex_ir),
    .ex_alu_out (ex_alu_out),
    .ex_carryout(ex_carryout),
    .ex_zeroout (ex_zeroout),
    .stall      (stall),
    .flush      (flush),
    .rs1_addr   (rs1_addr),
    .rs2_addr   (rs2_addr),
    .rd_data1   (rd_data1),
    .rd_data2   (rd_data2),
    .carry_flag (carry_flag),
    .zero_flag  (zero_flag),
    .wb_valid   (wb_valid),
    .wb_we      (wb_we),
    .wb_dest    (wb_dest),
    .wb_data    (wb_data)
  );

  typedef struct {
    logic        valid, stl, fls;
    logic [15:0] ir, alu;
    logic        co, zo;
    logic [2:0]  rs1, rs2;
    logic        e_valid, e_we;
    logic [2:0]  e_dest;
    logic [15:0] e_rd1, e_rd2;
    logic        e_c, e_z;
  } vec_t;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic s, input logic f, input logic [15:0] ir,
                       input logic [15:0] alu, input logic co, input logic zo);
    ex_valid = v; stall = s; flush = f; ex_ir = ir;
    ex_alu_out = alu; ex_carryout = co; ex_zeroout = zo;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  vec_t vecs [10];

  initial begin
    // Starting from reset: rf all 0, C=0, Z=0.
    vecs[0] = '{1,0,0, 16'h1012, 16'h1234, 1,1, 3'd2,3'd2, 1,0, 3'd2, 16'h0000,16'h0000, 0,0};
    vecs[1] = '{1,0,0, 16'h1298, 16'h00FF, 1,0, 3'd3,3'd2, 1,1, 3'd3, 16'h00FF,16'h0000, 1,0};
    vecs[2] = '{1,0,0, 16'h1008, 16'h0000, 0,1, 3'd3,3'd1, 1,1, 3'd1, 16'h00FF,16'h0000, 0,1};
    vecs[3] = '{1,0,0, 16'h2021, 16'h0000, 1,1, 3'd4,3'd1, 1,1, 3'd4, 16'h0000,16'h0000, 0,1};
    vecs[4] = '{1,0,0, 16'h0140, 16'hFFFE, 1,0, 3'd5,3'd3, 1,1, 3'd5, 16'hFFFE,16'h00FF, 1,0};
    vecs[5] = '{1,0,0, 16'h4000, 16'hAAAA, 0,1, 3'd5,3'd4, 1,0, 3'd0, 16'hFFFE,16'h0000, 1,0};
    vecs[6] = '{1,1,0, 16'h1298, 16'h5555, 0,1, 3'd3,3'd5, 0,0, 3'd0, 16'h00FF,16'hFFFE, 1,0};
    vecs[7] = '{0,0,0, 16'h0000, 16'h0000, 0,0, 3'd2,3'd4, 0,0, 3'd0, 16'h0000,16'h0000, 1,0};
    vecs[8] = '{1,0,0, 16'h1030, 16'h0F0F, 0,0, 3'd6,3'd6, 1,1, 3'd6, 16'h0F0F,16'h0F0F, 0,0};
    vecs[9] = '{1,0,1, 16'h1038, 16'h7777, 1,0, 3'd6,3'd7, 0,0, 3'd0, 16'h0F0F,16'h0000, 0,0};

    rst_n = 1'b0;
    drive(0, 0, 0, 16'h0, 16'h0, 0, 0);
    rs1_addr = 3'd0; rs2_addr = 3'd0;
    #1;
    chk("reset_wb_valid", {15'b0, wb_valid}, 16'h0);
    chk("reset_wb_we", {15'b0, wb_we}, 16'h0);
    chk("reset_wb_dest", {13'b0, wb_dest}, 16'h0);
    chk("reset_wb_data", wb_data, 16'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i].valid, vecs[i].stl, vecs[i].fls, vecs[i].ir, vecs[i].alu,
            vecs[i].co, vecs[i].zo);
      rs1_addr = vecs[i].rs1; rs2_addr = vecs[i].rs2;
      tick();
      chk($sformatf("v%0d_wb_valid", i), {15'b0, wb_valid}, {15'b0, vecs[i].e_valid});
      chk($sformatf("v%0d_wb_we", i), {15'b0, wb_we}, {15'b0, vecs[i].e_we});
      if (vecs[i].e_we) chk($sformatf("v%0d_wb_dest", i), {13'b0, wb_dest},
                             {13'b0, vecs[i].e_dest});
      chk($sformatf("v%0d_rd1", i), rd_data1, vecs[i].e_rd1);
      chk($sformatf("v%0d_rd2", i), rd_data2, vecs[i].e_rd2);
      chk($sformatf("v%0d_carry", i), {15'b0, carry_flag}, {15'b0, vecs[i].e_c});
      chk($sformatf("v%0d_zero", i), {15'b0, zero_flag}, {15'b0, vecs[i].e_z});
    end
    // Pending: nothing in WB (flushed). Arch C=0, Z=0, rf6=0F0F, rf7 must not be 7777.
    @(negedge clk);
    drive(0, 0, 0, 16'h0, 16'h0, 0, 0);
    rs1_addr = 3'd7; rs2_addr = 3'd2;
    tick();
    chk("flush_no_write_r7", rd_data1, 16'h0000);
    chk("skip_kept_r2", rd_data2, 16'h0000);

    // cc=11 is unconditional even though C=0 and Z=0.
    @(negedge clk);
    drive(1, 0, 0, 16'h2013, 16'hBEEF, 1, 0);
    rs1_addr = 3'd2;
    tick();
    chk("cc11_we", {15'b0, wb_we}, 16'h1);
    chk("cc11_carry_kept", {15'b0, carry_flag}, 16'h0);
    @(negedge clk);
    drive(0, 0, 0, 16'h0, 16'h0, 0, 0);
    tick();
    chk("cc11_r2", rd_data1, 16'hBEEF);

    // Register 0 behaviour.
    @(negedge clk);
    drive(1, 0, 0, 16'h1000, 16'h1111, 1, 0);
    rs1_addr = 3'd0; rs2_addr = 3'd0;
    tick();
`ifdef R0_ZERO_EN
    chk("r0_we", {15'b0, wb_we}, 16'h0);
    chk("r0_bypass_rd1", rd_data1, 16'h0000);
`else
    chk("r0_we", {15'b0, wb_we}, 16'h1);
    chk("r0_bypass_rd1", rd_data1, 16'h1111);
`endif
    chk("r0_carry", {15'b0, carry_flag}, 16'h1);
    @(negedge clk);
    drive(0, 0, 0, 16'h0, 16'h0, 0, 0);
    tick();
`ifdef R0_ZERO_EN
    chk("r0_after", rd_data2, 16'h0000);
`else
    chk("r0_after", rd_data2, 16'h1111);
`endif
    chk("r0_arch_carry", {15'b0, carry_flag}, 16'h1);

    // Reset in the middle of a pending commit to r7 must abort it.
    @(negedge clk);
    drive(1, 0, 0, 16'h1038, 16'h7777, 1, 1);
    tick();
    chk("pre_reset_we", {15'b0, wb_we}, 16'h1);
    drive(0, 0, 0, 16'h0, 16'h0, 0, 0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_reset_wb_valid", {15'b0, wb_valid}, 16'h0);
    chk("mid_reset_carry", {15'b0, carry_flag}, 16'h0);
    chk("mid_reset_zero", {15'b0, zero_flag}, 16'h0);
    @(posedge clk);
    #1;
    for (int r = 0; r < 8; r++) begin
      rs1_addr = 3'(r); rs2_addr = 3'(7 - r);
      #1;
      chk($sformatf("reset_r%0d_p1", r), rd_data1, 16'h0000);
      chk($sformatf("reset_r%0d_p2", 7 - r), rd_data2, 16'h0000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_reset_wb_valid", {15'b0, wb_valid}, 16'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
